button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//  Turns NBTN debounced button levels into single press events and queues them per button.
//  Grants one event at a time, round-robin, to the game FSM over a valid/ready handshake.
//  Adds optional hold-to-repeat events for the most recently pressed button.
//  Sits between the per-button debouncer instances and the TicTacToe cursor/move FSM.
// PARAMETERS
//  NBTN          5        number of buttons (2..8)
//  IW            3        event index width, >= clog2(NBTN)
//  REPEAT_DELAY  24'd0    clk cycles from press grant to first repeat; 0 disables repeat
//  REPEAT_RATE   24'd0    clk cycles between later repeats; must be >0 if REPEAT_DELAY>0
// PORTS
//  clk         in   1     system clock, all flops posedge
//  rst_n       in   1     asynchronous active-low reset
//  btn_db      in   NBTN  debounced button levels, synchronous to clk
//  enable      in   1     0 = drop pending events, ignore presses, stop repeat
//  evt_valid   out  1     event presented; held until accepted
//  evt_ready   in   1     consumer accepts when evt_valid & evt_ready at posedge
//  evt_id      out  IW    button index of the presented event
//  evt_repeat  out  1     1 = auto-repeat event, 0 = fresh press
//  pending     out  NBTN  per-button queued-event flags, for debug/LEDs
// BEHAVIOUR
//  Reset: evt_valid=0, evt_id=0, evt_repeat=0, pending=0, rr_ptr=NBTN-1, repeat FSM=IDLE,
//   timer=0, armed=0.
//  Arming: the first posedge after reset loads prev<=btn_db and sets armed=1 with no events.
//   A button held through reset makes no press.
//  Edge: rise = btn_db & ~prev & {NBTN{armed&enable}}. prev<=btn_db on every edge.
//  Queue: rise[i] sets pending[i] and clears rep_flag[i]. A press overrides a queued repeat.
//   Each bit holds one event. A second rise while the bit is set is merged, not counted.
//  Latency: btn_db[i] rises before edge k -> pending[i]=1 after k ->
//   evt_valid=1, evt_id=i after k+1, if the slot is free and i wins.
//  Slot load: when (!evt_valid | evt_ready) & |pending, grant the first set bit
//   scanning rr_ptr+1, rr_ptr+2, ... modulo NBTN.
//   Then evt_valid<=1, evt_id<=idx, evt_repeat<=rep_flag[idx], rr_ptr<=idx, clear pending[idx].
//   Accept and reload happen in the same cycle, so back-to-back events run at full rate.
//   If nothing is pending, accept drops evt_valid to 0.
//  Simultaneous: rise[i] in the cycle that grants i leaves pending[i]=1, a new event.
//  Output stability: while evt_valid & !evt_ready, evt_id and evt_repeat must not change.
//  Repeat FSM (inactive when REPEAT_DELAY==0):
//   IDLE  -> DELAY on a press grant (evt_repeat=0) of idx. hold_id<=idx, timer<=0.
//   DELAY -> timer++. At timer==REPEAT_DELAY-1, set pending[hold_id] and rep_flag[hold_id],
//            timer<=0, go to RPT.
//   RPT   -> timer++. At timer==REPEAT_RATE-1, set pending/rep_flag of hold_id again, timer<=0.
//   Any state: a press grant of another index re-targets (hold_id<=idx, DELAY, timer<=0).
//   Any state -> IDLE when btn_db[hold_id]==0 or enable==0. Queued repeats are kept.
//   A repeat whose pending bit is already set is merged, so there is no backlog.
//   A repeat set and rise[hold_id] in the same cycle: the press wins, rep_flag=0.
//  enable=0: pending and rep_flag cleared each cycle; no new loads.
//   An event already in the slot stays valid until accepted.
//  Width: timer is 24 bits, counting from 0 to param-1 and never wrapping.
//   rr_ptr is always < NBTN, with an explicit wrap at NBTN-1.
//  Reset mid-operation: all state returns to reset values asynchronously and the event is lost.
// TESTING
//  T1 after reset, pulse btn_db[2] high for 20 cycles, evt_ready=1
//     -> exactly one event, id=2, repeat=0, valid 2 cycles after rise, for 1 cycle.
//  T2 btn_db[0] and btn_db[3] rise together, rr_ptr=4, evt_ready=1
//     -> events id=0 then id=3 on consecutive cycles.
//  T3 evt_ready=0, press btn 1 and then btn 4
//     -> valid id=1 held stable; pending=5'b10000.
//     Raising ready gives id=1, then id=4 on the next cycle.
//  T4 REPEAT_DELAY=10, REPEAT_RATE=4, hold btn 3 for 30 cycles, ready=1
//     -> press event, first repeat 10 cycles after grant+1, then repeats every 4; none after release.
//  T5 btn 2 held across rst_n assert/deassert
//     -> no event. Release and re-press -> one event id=2.
//  T6 queue 3 events with ready=0, drop enable
//     -> pending=0 and the slot event is still valid. Re-enable -> no stale events.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into queued press/repeat events and hands them out
// one at a time, round-robin, over a valid/ready handshake.
module button_event_arbiter #(
    parameter int          NBTN         = 5,
    parameter int          IW           = 3,
    parameter logic [23:0] REPEAT_DELAY = 24'd0,
    parameter logic [23:0] REPEAT_RATE  = 24'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn_db,
    input  logic            enable,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IW-1:0]   evt_id,
    output logic            evt_repeat,
    output logic [NBTN-1:0] pending
);

    // Handshake: an event transfers when evt_valid & evt_ready at posedge; while
    // evt_valid is high and evt_ready low, evt_id/evt_repeat hold their values.

    localparam int SW = IW + 1;

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RUN   = 2'd2
    } rpt_state_t;

    rpt_state_t      rpt_state, rpt_state_n;
    logic [NBTN-1:0] prev;
    logic            armed;
    logic [NBTN-1:0] rep_flag;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   hold_id, hold_id_n;
    logic [23:0]     timer, timer_n;

    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] pending_n, rep_flag_n;
    logic            load;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic            press_grant;
    logic            rpt_fire;
    logic [SW-1:0]   cand;

    assign rise = btn_db & ~prev & {NBTN{armed & enable}};
    assign load = enable & (~evt_valid | evt_ready) & (|pending);
    assign press_grant = load & ~rep_flag[grant_idx];

    // Round-robin scan starting just after the last granted index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NBTN; k++) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(NBTN)) begin
                cand = cand - SW'(NBTN);
            end
            if (!grant_found && pending[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        rpt_state_n = rpt_state;
        hold_id_n   = hold_id;
        timer_n     = timer;
        rpt_fire    = 1'b0;
        if (REPEAT_DELAY != 24'd0) begin
            if (press_grant) begin
                rpt_state_n = RPT_DELAY;
                hold_id_n   = grant_idx;
                timer_n     = '0;
            end else if (rpt_state != RPT_IDLE && (!btn_db[hold_id] || !enable)) begin
                rpt_state_n = RPT_IDLE;
                timer_n     = '0;
            end else begin
                case (rpt_state)
                    RPT_DELAY: begin
                        if (timer == REPEAT_DELAY - 24'd1) begin
                            rpt_fire    = 1'b1;
                            timer_n     = '0;
                            rpt_state_n = RPT_RUN;
                        end else begin
                            timer_n = timer + 24'd1;
                        end
                    end
                    RPT_RUN: begin
                        if (timer == REPEAT_RATE - 24'd1) begin
                            rpt_fire = 1'b1;
                            timer_n  = '0;
                        end else begin
                            timer_n = timer + 24'd1;
                        end
                    end
                    default: begin
                        timer_n = '0;
                    end
                endcase
            end
        end
    end

    // Grant clears first, then a repeat merges into an empty bit, then a press overrides.
    always_comb begin
        pending_n  = pending;
        rep_flag_n = rep_flag;
        if (!enable) begin
            pending_n  = '0;
            rep_flag_n = '0;
        end else begin
            if (load) begin
                pending_n[grant_idx] = 1'b0;
            end
            if (rpt_fire && !pending_n[hold_id]) begin
                pending_n[hold_id]  = 1'b1;
                rep_flag_n[hold_id] = 1'b1;
            end
            pending_n  = pending_n | rise;
            rep_flag_n = rep_flag_n & ~rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            armed      <= 1'b0;
            pending    <= '0;
            rep_flag   <= '0;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            evt_repeat <= 1'b0;
            rr_ptr     <= IW'(NBTN - 1);
            rpt_state  <= RPT_IDLE;
            hold_id    <= '0;
            timer      <= '0;
        end else begin
            prev      <= btn_db;
            armed     <= 1'b1;
            pending   <= pending_n;
            rep_flag  <= rep_flag_n;
            rpt_state <= rpt_state_n;
            hold_id   <= hold_id_n;
            timer     <= timer_n;
            if (load) begin
                evt_valid  <= 1'b1;
                evt_id     <= grant_idx;
                evt_repeat <= rep_flag[grant_idx];
                rr_ptr     <= grant_idx;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: one default instance and one with repeat enabled,
// each with a scoreboard of expected events tagged with the cycle they must be accepted in.
module tb_button_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic       enable;
    logic       ready;
    logic       valid;
    logic [2:0] id;
    logic       rep;
    logic [4:0] pend;

    logic [4:0] btn2;
    logic       enable2;
    logic       ready2;
    logic       valid2;
    logic [2:0] id2;
    logic       rep2;
    logic [4:0] pend2;

    int cyc;
    int n_checks;
    int n_pass;
    int n_fail;
    int n;

    // entry = {accept cycle[15:0], repeat, id[2:0]}
    logic [19:0] exp_q[$];
    logic [19:0] exp2_q[$];

    logic       held;
    logic [2:0] held_id;
    logic       held_rep;

    button_event_arbiter #(.NBTN(5), .IW(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_db(btn), .enable(enable),
        .evt_valid(valid), .evt_ready(ready), .evt_id(id), .evt_repeat(rep),
        .pending(pend)
    );

    button_event_arbiter #(.NBTN(5), .IW(3), .REPEAT_DELAY(24'd10), .REPEAT_RATE(24'd4)) dut_rpt (
        .clk(clk), .rst_n(rst_n), .btn_db(btn2), .enable(enable2),
        .evt_valid(valid2), .evt_ready(ready2), .evt_id(id2), .evt_repeat(rep2),
        .pending(pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic r, input logic [2:0] i);
        exp_q.push_back({c[15:0], r, i});
    endtask

    task automatic push2(input int c, input logic r, input logic [2:0] i);
        exp2_q.push_back({c[15:0], r, i});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
        end else begin
            if (held && valid) begin
                check("stable_id", id, held_id);
                check("stable_rep", rep, held_rep);
            end
            if (valid && ready) begin
                check("evt_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("evt", {cyc[15:0], rep, id}, exp_q.pop_front());
                end
            end
            held     <= valid && !ready;
            held_id  <= id;
            held_rep <= rep;
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid2 && ready2) begin
            check("evt2_expected", exp2_q.size() > 0, 1);
            if (exp2_q.size() > 0) begin
                check("evt2", {cyc[15:0], rep2, id2}, exp2_q.pop_front());
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn      = '0;
        enable   = 1'b1;
        ready    = 1'b1;
        btn2     = '0;
        enable2  = 1'b1;
        ready2   = 1'b1;
        tick(3);
        check("rst_valid", valid, 0);
        check("rst_id", id, 0);
        check("rst_repeat", rep, 0);
        check("rst_pending", pend, 0);
        check("rst_valid2", valid2, 0);
        check("rst_pending2", pend2, 0);
        rst_n = 1'b1;
        tick(2);

        // T1: single 20-cycle press
        btn[2] = 1'b1;
        push(cyc + 2, 1'b0, 3'd2);
        tick(1);
        check("t1_pending", pend, 5'b00100);
        tick(1);
        check("t1_valid", valid, 1);
        check("t1_id", id, 2);
        tick(1);
        check("t1_valid_drop", valid, 0);
        tick(17);
        btn[2] = 1'b0;
        tick(4);
        check("t1_drained", exp_q.size(), 0);

        // T2: move rr_ptr to 4, then simultaneous 0 and 3
        btn[4] = 1'b1;
        push(cyc + 2, 1'b0, 3'd4);
        tick(3);
        btn[4] = 1'b0;
        tick(2);
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        push(cyc + 2, 1'b0, 3'd0);
        push(cyc + 3, 1'b0, 3'd3);
        tick(6);
        btn = '0;
        tick(3);
        check("t2_drained", exp_q.size(), 0);

        // T3: back-pressure holds the slot, second press waits in pending
        ready  = 1'b0;
        btn[1] = 1'b1;
        tick(3);
        btn[4] = 1'b1;
        tick(3);
        check("t3_valid", valid, 1);
        check("t3_id", id, 1);
        check("t3_pending", pend, 5'b10000);
        push(cyc, 1'b0, 3'd1);
        push(cyc + 1, 1'b0, 3'd4);
        ready = 1'b1;
        tick(4);
        btn = '0;
        tick(3);
        check("t3_drained", exp_q.size(), 0);

        // T4: hold-to-repeat on the repeat instance
        n = cyc;
        btn2[3] = 1'b1;
        push2(n + 2, 1'b0, 3'd3);
        for (int k = 0; k < 5; k++) begin
            push2(n + 13 + 4 * k, 1'b1, 3'd3);
        end
        tick(30);
        btn2[3] = 1'b0;
        tick(15);
        check("t4_drained", exp2_q.size(), 0);
        check("t4_valid_idle", valid2, 0);

        // T5: button held across reset makes no press
        rst_n  = 1'b0;
        btn[2] = 1'b1;
        tick(1);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_pending", pend, 0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("t5_no_pending", pend, 0);
        check("t5_no_valid", valid, 0);
        btn[2] = 1'b0;
        tick(3);
        btn[2] = 1'b1;
        push(cyc + 2, 1'b0, 3'd2);
        tick(4);
        btn[2] = 1'b0;
        tick(3);
        check("t5_drained", exp_q.size(), 0);

        // T6: disable drops queued events but not the slot
        ready  = 1'b0;
        btn[0] = 1'b1;
        tick(3);
        btn[1] = 1'b1;
        btn[3] = 1'b1;
        tick(3);
        check("t6_pending", pend, 5'b01010);
        check("t6_valid", valid, 1);
        check("t6_id", id, 0);
        enable = 1'b0;
        tick(1);
        check("t6_dis_pending", pend, 0);
        check("t6_dis_valid", valid, 1);
        check("t6_dis_id", id, 0);
        btn[4] = 1'b1;
        tick(1);
        check("t6_dis_press", pend, 0);
        enable = 1'b1;
        push(cyc, 1'b0, 3'd0);
        ready = 1'b1;
        tick(6);
        check("t6_no_stale_valid", valid, 0);
        check("t6_no_stale_pending", pend, 0);
        btn = '0;
        tick(3);
        check("t6_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
